// File: rtl/tictactoe_game_ctrl_if.sv
// Move request/response handshake between a player front-end and the
// tic-tac-toe game controller.
interface tictactoe_game_ctrl_if;
    logic       iMoveValid;
    logic [1:0] iMoveRow;
    logic [1:0] iMoveCol;
    logic       oMoveReady;
    logic       oMoveAccept;
    logic       oMoveReject;

    modport master (output iMoveValid, iMoveRow, iMoveCol,
                    input  oMoveReady, oMoveAccept, oMoveReject);
    modport slave  (input  iMoveValid, iMoveRow, iMoveCol,
                    output oMoveReady, oMoveAccept, oMoveReject);
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: move legality check, board update, serial line scan.
// Optional TTT_SCORE_EN adds per-player win counters (oScoreX/oScoreO).
module tictactoe_game_ctrl (
    input  logic                        Clock,
    input  logic                        Reset,
    tictactoe_game_ctrl_if.slave        mv,
    input  logic                        iNewGame,
    output logic [0:17]                 oSymVector,
    output logic                        oTurn,
    output logic                        oWinFlag,
    output logic [1:0]                  oWinner,
    output logic                        oDrawFlag,
    output logic [3:0]                  oMoveCount
`ifdef TTT_SCORE_EN
    ,
    output logic [3:0]                  oScoreX,
    output logic [3:0]                  oScoreO
`endif
);
    localparam logic [1:0] SYM_E = 2'b00;
    localparam logic [1:0] SYM_X = 2'b01;
    localparam logic [1:0] SYM_O = 2'b10;

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, WIN, DRAW} state_e;

    state_e           state_q;
    logic [8:0][1:0]  board_q;
    logic [1:0]       row_q, col_q;
    logic [2:0]       idx_q, hidx_q;
    logic             hit_q, hvld_q;
    logic             turn_q, win_q, draw_q;
    logic [1:0]       winner_q;
    logic [3:0]       cnt_q;
    logic             ready_q, acc_q, rej_q;
`ifdef TTT_SCORE_EN
    logic [3:0]       score_x_q, score_o_q;
`endif

    logic [1:0] mover_d;
    logic       rc_ok_d, tgt_free_d, line_hit_d;
    logic [3:0] tgt_idx_d;

    // Cell number (3*row+col) of the j-th cell of scan line idx.
    function automatic logic [3:0] line_cell(input logic [2:0] idx, input logic [1:0] j);
        logic [3:0] jj;
        logic [3:0] ii;
        jj = {2'b00, j};
        ii = {1'b0, idx};
        case (idx)
            3'd0, 3'd1, 3'd2: line_cell = ii * 4'd3 + jj;
            3'd3, 3'd4, 3'd5: line_cell = (ii - 4'd3) + jj * 4'd3;
            3'd6:             line_cell = jj * 4'd4;
            default:          line_cell = 4'd2 + jj * 4'd2;
        endcase
    endfunction

    always_comb begin
        mover_d    = turn_q ? SYM_O : SYM_X;
        rc_ok_d    = (row_q != 2'd3) && (col_q != 2'd3);
        tgt_idx_d  = rc_ok_d ? ({2'b00, row_q} * 4'd3 + {2'b00, col_q}) : 4'd0;
        tgt_free_d = rc_ok_d && (board_q[tgt_idx_d] == SYM_E);
        line_hit_d = 1'b1;
        for (int j = 0; j < 3; j++)
            if (board_q[line_cell(idx_q, 2'(j))] != mover_d) line_hit_d = 1'b0;
    end

    // The line compare is registered, so each SCAN decision acts on the
    // line fetched one cycle earlier; the last decision lands 10 edges after sampling.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            board_q   <= '0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            idx_q     <= 3'd0;
            hidx_q    <= 3'd0;
            hit_q     <= 1'b0;
            hvld_q    <= 1'b0;
            turn_q    <= 1'b0;
            win_q     <= 1'b0;
            draw_q    <= 1'b0;
            winner_q  <= SYM_E;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            acc_q     <= 1'b0;
            rej_q     <= 1'b0;
`ifdef TTT_SCORE_EN
            score_x_q <= 4'd0;
            score_o_q <= 4'd0;
`endif
        end else begin
            acc_q <= 1'b0;
            rej_q <= 1'b0;
            if (iNewGame) begin
                state_q  <= IDLE;
                board_q  <= '0;
                hvld_q   <= 1'b0;
                turn_q   <= 1'b0;
                win_q    <= 1'b0;
                draw_q   <= 1'b0;
                winner_q <= SYM_E;
                cnt_q    <= 4'd0;
                ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        ready_q <= 1'b1;
                        if (ready_q && mv.iMoveValid) begin
                            row_q   <= mv.iMoveRow;
                            col_q   <= mv.iMoveCol;
                            ready_q <= 1'b0;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (tgt_free_d) begin
                            board_q[tgt_idx_d] <= mover_d;
                            cnt_q   <= cnt_q + 4'd1;
                            acc_q   <= 1'b1;
                            idx_q   <= 3'd0;
                            hvld_q  <= 1'b0;
                            state_q <= SCAN;
                        end else begin
                            rej_q   <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    SCAN: begin
                        hit_q  <= line_hit_d;
                        hidx_q <= idx_q;
                        hvld_q <= 1'b1;
                        idx_q  <= idx_q + 3'd1;
                        if (hvld_q && hit_q) begin
                            win_q    <= 1'b1;
                            winner_q <= mover_d;
                            state_q  <= WIN;
`ifdef TTT_SCORE_EN
                            if (!turn_q) begin
                                if (score_x_q != 4'hF) score_x_q <= score_x_q + 4'd1;
                            end else begin
                                if (score_o_q != 4'hF) score_o_q <= score_o_q + 4'd1;
                            end
`endif
                        end else if (hvld_q && hidx_q == 3'd7) begin
                            if (cnt_q == 4'd9) begin
                                draw_q  <= 1'b1;
                                state_q <= DRAW;
                            end else begin
                                turn_q  <= ~turn_q;
                                ready_q <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: ready_q <= 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        oSymVector = '0;
        for (int k = 0; k < 9; k++) oSymVector[2*k +: 2] = board_q[k];
    end

    assign mv.oMoveReady  = ready_q;
    assign mv.oMoveAccept = acc_q;
    assign mv.oMoveReject = rej_q;
    assign oTurn          = turn_q;
    assign oWinFlag       = win_q;
    assign oWinner        = winner_q;
    assign oDrawFlag      = draw_q;
    assign oMoveCount     = cnt_q;
`ifdef TTT_SCORE_EN
    assign oScoreX        = score_x_q;
    assign oScoreO        = score_o_q;
`endif
endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Scoreboard bench for tictactoe_game_ctrl: expected pulses queued at drive time,
// observed pulses queued by a monitor, both compared inside each scenario task.
module tb_tictactoe_game_ctrl;
    logic        Clock;
    logic        Reset;
    logic        iNewGame;
    logic [0:17] oSymVector;
    logic        oTurn, oWinFlag, oDrawFlag;
    logic [1:0]  oWinner;
    logic [3:0]  oMoveCount;
`ifdef TTT_SCORE_EN
    logic [3:0]  oScoreX, oScoreO;
`endif

    tictactoe_game_ctrl_if mv();

    tictactoe_game_ctrl dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .mv         (mv),
        .iNewGame   (iNewGame),
        .oSymVector (oSymVector),
        .oTurn      (oTurn),
        .oWinFlag   (oWinFlag),
        .oWinner    (oWinner),
        .oDrawFlag  (oDrawFlag),
        .oMoveCount (oMoveCount)
`ifdef TTT_SCORE_EN
        ,
        .oScoreX    (oScoreX),
        .oScoreO    (oScoreO)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];
    logic [1:0] mdl [9];

    // Pulse codes: 1 accept, 0 reject, 2 both at once.
    always @(posedge Clock) begin
        #1;
        if (mv.oMoveAccept && mv.oMoveReject) obs_q.push_back(2);
        else if (mv.oMoveAccept)              obs_q.push_back(1);
        else if (mv.oMoveReject)              obs_q.push_back(0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int pop_obs();
        if (obs_q.size() == 0) return -1;
        return obs_q.pop_front();
    endfunction

    function automatic logic [0:17] exp_sym();
        logic [0:17] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[2*k +: 2] = mdl[k];
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 9; k++) mdl[k] = 2'b00;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic new_game();
        iNewGame = 1'b1;
        tick();
        iNewGame = 1'b0;
        clear_model();
    endtask

    // Waits for ready, issues one move, returns edges from sampling edge until
    // ready or a terminal flag (-1 on timeout).
    task automatic send_move(input logic [1:0] r, input logic [1:0] c, input int code,
                             output int waited);
        int n;
        n = 0;
        exp_q.push_back(code);
        while (!mv.oMoveReady && n < 40) begin
            tick();
            n++;
        end
        mv.iMoveValid = 1'b1;
        mv.iMoveRow   = r;
        mv.iMoveCol   = c;
        tick();
        mv.iMoveValid = 1'b0;
        waited = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (mv.oMoveReady || oWinFlag || oDrawFlag) begin
                waited = k;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        iNewGame = 1'b1;
        mv.iMoveValid = 1'b1;
        mv.iMoveRow = 2'd1;
        mv.iMoveCol = 2'd1;
        repeat (3) tick();
        checks++;
        if (mv.oMoveReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", mv.oMoveReady); end
        checks++;
        if ({oSymVector, oTurn, oWinFlag, oWinner, oDrawFlag, oMoveCount} !== 27'd0) begin
            errors++; $display("FAIL rst_state got sym=%h turn=%b win=%b wnr=%b draw=%b cnt=%0d want all zero",
                               oSymVector, oTurn, oWinFlag, oWinner, oDrawFlag, oMoveCount);
        end
        checks++;
        if ({mv.oMoveAccept, mv.oMoveReject} !== 2'b00) begin
            errors++; $display("FAIL rst_pulses got %b%b want 00", mv.oMoveAccept, mv.oMoveReject);
        end
        iNewGame = 1'b0;
        mv.iMoveValid = 1'b0;
        Reset = 1'b1;
        checks++;
        if (mv.oMoveReady !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %b want 0", mv.oMoveReady); end
        tick();
        checks++;
        if (mv.oMoveReady !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready got %b want 1", mv.oMoveReady); end
        clear_model();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_first_move();
        int w, got, want;
        logic [1:0] c0;
        send_move(2'd0, 2'd0, 1, w);
        checks++;
        if (w !== 10) begin errors++; $display("FAIL first_latency got %0d want 10", w); end
        got = pop_obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin errors++; $display("FAIL first_pulse got %0d want %0d", got, want); end
        mdl[0] = 2'b01;
        c0 = oSymVector[0:1];
        checks++;
        if (c0 !== 2'b01) begin errors++; $display("FAIL first_cell got %b want 01", c0); end
        checks++;
        if ({oTurn, oMoveCount} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL first_turn_cnt got turn=%b cnt=%0d want turn=1 cnt=1", oTurn, oMoveCount);
        end
    endtask

    task automatic test_reject();
        int w, got, want;
        int t [2][3] = '{'{0, 0, 1}, '{3, 0, 1}};
        for (int i = 0; i < 2; i++) begin
            send_move(2'(t[i][0]), 2'(t[i][1]), 0, w);
            checks++;
            if (w !== t[i][2]) begin errors++; $display("FAIL rej_latency[%0d] got %0d want %0d", i, w, t[i][2]); end
            got = pop_obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL rej_pulse[%0d] got %0d want %0d", i, got, want); end
        end
        checks++;
        if (oSymVector !== exp_sym()) begin errors++; $display("FAIL rej_board got %h want %h", oSymVector, exp_sym()); end
        checks++;
        if ({oTurn, oMoveCount} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL rej_turn_cnt got turn=%b cnt=%0d want turn=1 cnt=1", oTurn, oMoveCount);
        end
    endtask

    task automatic test_win();
        int w, got, want;
        // row, col, latency, symbol
        int t [5][4] = '{'{0, 0, 10, 1}, '{1, 0, 10, 2}, '{0, 1, 10, 1}, '{1, 1, 10, 2}, '{0, 2, 3, 1}};
        new_game();
        for (int i = 0; i < 5; i++) begin
            send_move(2'(t[i][0]), 2'(t[i][1]), 1, w);
            checks++;
            if (w !== t[i][2]) begin errors++; $display("FAIL win_latency[%0d] got %0d want %0d", i, w, t[i][2]); end
            got = pop_obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL win_pulse[%0d] got %0d want %0d", i, got, want); end
            mdl[3*t[i][0] + t[i][1]] = 2'(t[i][3]);
        end
        checks++;
        if ({oWinFlag, oWinner, oDrawFlag} !== 4'b1010) begin
            errors++; $display("FAIL win_flags got win=%b wnr=%b draw=%b want 1 01 0", oWinFlag, oWinner, oDrawFlag);
        end
        mv.iMoveValid = 1'b1;
        mv.iMoveRow = 2'd2;
        mv.iMoveCol = 2'd2;
        repeat (4) tick();
        mv.iMoveValid = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs_q.size() != 0 || mv.oMoveReady !== 1'b0) begin
            errors++; $display("FAIL win_frozen_hs got pulses=%0d ready=%b want 0 0", obs_q.size(), mv.oMoveReady);
        end
        checks++;
        if (oSymVector !== exp_sym() || oMoveCount !== 4'd5) begin
            errors++; $display("FAIL win_frozen_board got %h cnt=%0d want %h cnt=5", oSymVector, oMoveCount, exp_sym());
        end
    endtask

    task automatic test_draw();
        int w, got, want;
        int t [9][3] = '{'{0, 0, 1}, '{0, 1, 2}, '{0, 2, 1}, '{1, 1, 2}, '{1, 0, 1},
                         '{1, 2, 2}, '{2, 1, 1}, '{2, 0, 2}, '{2, 2, 1}};
        new_game();
        for (int i = 0; i < 9; i++) begin
            send_move(2'(t[i][0]), 2'(t[i][1]), 1, w);
            checks++;
            if (w !== 10) begin errors++; $display("FAIL draw_latency[%0d] got %0d want 10", i, w); end
            got = pop_obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL draw_pulse[%0d] got %0d want %0d", i, got, want); end
            mdl[3*t[i][0] + t[i][1]] = 2'(t[i][2]);
        end
        checks++;
        if ({oDrawFlag, oWinFlag, oMoveCount, mv.oMoveReady} !== {1'b1, 1'b0, 4'd9, 1'b0}) begin
            errors++; $display("FAIL draw_flags got draw=%b win=%b cnt=%0d ready=%b want 1 0 9 0",
                               oDrawFlag, oWinFlag, oMoveCount, mv.oMoveReady);
        end
        checks++;
        if (oSymVector !== exp_sym()) begin errors++; $display("FAIL draw_board got %h want %h", oSymVector, exp_sym()); end
    endtask

    task automatic test_newgame();
        int w, got, want;
        new_game();
        send_move(2'd2, 2'd2, 1, w);
        got = pop_obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want || w !== 10) begin errors++; $display("FAIL ng_setup got pulse=%0d lat=%0d want %0d 10", got, w, want); end
        // New game and move request sampled on the same edge.
        mv.iMoveValid = 1'b1; mv.iMoveRow = 2'd0; mv.iMoveCol = 2'd0;
        iNewGame = 1'b1;
        tick();
        mv.iMoveValid = 1'b0; iNewGame = 1'b0;
        clear_model();
        repeat (12) tick();
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL ng_same_cycle_pulse got %0d pulses want 0", obs_q.size()); end
        checks++;
        if ({oSymVector, oTurn, oMoveCount, mv.oMoveReady} !== {18'd0, 1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL ng_same_cycle_state got sym=%h turn=%b cnt=%0d ready=%b want 0 0 0 1",
                               oSymVector, oTurn, oMoveCount, mv.oMoveReady);
        end
        // Abort in CHECK: no pulse at all.
        mv.iMoveValid = 1'b1; mv.iMoveRow = 2'd1; mv.iMoveCol = 2'd1;
        tick();
        mv.iMoveValid = 1'b0; iNewGame = 1'b1;
        tick();
        iNewGame = 1'b0;
        repeat (12) tick();
        checks++;
        if (obs_q.size() != 0 || oMoveCount !== 4'd0 || oSymVector !== 18'd0) begin
            errors++; $display("FAIL ng_check_abort got pulses=%0d cnt=%0d sym=%h want 0 0 0", obs_q.size(), oMoveCount, oSymVector);
        end
        // Abort mid-SCAN: accept already issued, nothing further.
        exp_q.push_back(1);
        mv.iMoveValid = 1'b1; mv.iMoveRow = 2'd1; mv.iMoveCol = 2'd1;
        tick();
        mv.iMoveValid = 1'b0;
        repeat (4) tick();
        iNewGame = 1'b1;
        tick();
        iNewGame = 1'b0;
        repeat (12) tick();
        got = pop_obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want || obs_q.size() != 0) begin
            errors++; $display("FAIL ng_scan_abort_pulse got %0d extra=%0d want %0d 0", got, obs_q.size(), want);
        end
        checks++;
        if ({oSymVector, oTurn, oMoveCount, mv.oMoveReady} !== {18'd0, 1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL ng_scan_abort_state got sym=%h turn=%b cnt=%0d ready=%b want 0 0 0 1",
                               oSymVector, oTurn, oMoveCount, mv.oMoveReady);
        end
    endtask

    task automatic test_reset_inflight();
        exp_q.push_back(1);
        mv.iMoveValid = 1'b1; mv.iMoveRow = 2'd0; mv.iMoveCol = 2'd2;
        tick();
        mv.iMoveValid = 1'b0;
        repeat (4) tick();
        Reset = 1'b0; iNewGame = 1'b1;
        tick();
        Reset = 1'b1; iNewGame = 1'b0;
        checks++;
        if ({oSymVector, oTurn, oMoveCount, mv.oMoveReady} !== {18'd0, 1'b0, 4'd0, 1'b0}) begin
            errors++; $display("FAIL rst_inflight_state got sym=%h turn=%b cnt=%0d ready=%b want 0 0 0 0",
                               oSymVector, oTurn, oMoveCount, mv.oMoveReady);
        end
        repeat (12) tick();
        checks++;
        if (pop_obs() !== exp_q.pop_front() || obs_q.size() != 0 || mv.oMoveReady !== 1'b1) begin
            errors++; $display("FAIL rst_inflight_after got extra=%0d ready=%b want 0 1", obs_q.size(), mv.oMoveReady);
        end
    endtask

`ifdef TTT_SCORE_EN
    task automatic test_score();
        int w;
        int t [5][2] = '{'{0, 0}, '{1, 0}, '{0, 1}, '{1, 1}, '{0, 2}};
        for (int g = 0; g < 16; g++) begin
            new_game();
            for (int i = 0; i < 5; i++) send_move(2'(t[i][0]), 2'(t[i][1]), 1, w);
        end
        checks++;
        if ({oScoreX, oScoreO} !== {4'd15, 4'd0}) begin
            errors++; $display("FAIL score_sat got x=%0d o=%0d want 15 0", oScoreX, oScoreO);
        end
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if ({oScoreX, oScoreO} !== 8'd0) begin errors++; $display("FAIL score_reset got x=%0d o=%0d want 0 0", oScoreX, oScoreO); end
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        Reset = 1'b0;
        iNewGame = 1'b0;
        mv.iMoveValid = 1'b0;
        mv.iMoveRow = 2'd0;
        mv.iMoveCol = 2'd0;
        clear_model();
        test_reset();
        test_first_move();
        test_reject();
        test_win();
        test_draw();
        test_newgame();
        test_reset_inflight();
`ifdef TTT_SCORE_EN
        test_score();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
